// File: rtl/param_bus_slave.sv
// Single-outstanding bus slave with byte-strobed word storage, alternating
// write/read arbitration on ties and a configurable read response latency.
module param_bus_slave #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wvalid,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wready,
    output logic                    bvalid,
    output logic                    berr,
    input  logic                    bready,
    input  logic                    arvalid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    arready,
    output logic                    rvalid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rerr,
    input  logic                    rready,
    output logic [15:0]             wr_count,
    output logic [15:0]             rd_count,
    output logic [15:0]             err_count,
    output logic [1:0]              state
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = (NB > 1) ? $clog2(NB) : 0;
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK  = ADDR_WIDTH'(NB - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
    localparam logic [2:0]            WAIT_INIT = (RD_LATENCY > 1) ? 3'(RD_LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_RESP = 2'd1,
        RD_WAIT = 2'd2,
        RD_RESP = 2'd3
    } state_t;

    state_t                state_q;
    logic                  lastWrite_q;
    logic                  bvalid_q, berr_q, rvalid_q, rerr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [IW-1:0]         rdIdx_q;
    logic                  rdErr_q;
    logic [2:0]            waitCnt_q;
    logic [15:0]           wrCnt_q, rdCnt_q, errCnt_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wIdxFull, rIdxFull;
    logic                  wErr, rErr, wHs, rHs, bHs, rdHs;

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign wIdxFull = waddr >> OFF;
    assign rIdxFull = araddr >> OFF;
    assign wErr     = ((waddr & LOW_MASK) != '0) || (wIdxFull >= DEPTH_A);
    assign rErr     = ((araddr & LOW_MASK) != '0) || (rIdxFull >= DEPTH_A);

    // On a tie the channel that did not win last time is granted.
    assign wready  = !rst && (state_q == IDLE) && wvalid && (!arvalid || !lastWrite_q);
    assign arready = !rst && (state_q == IDLE) && arvalid && (!wvalid || lastWrite_q);

    assign wHs  = wvalid && wready;
    assign rHs  = arvalid && arready;
    assign bHs  = bvalid_q && bready;
    assign rdHs = rvalid_q && rready;

    // Storage is deliberately outside the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (wHs && !wErr) begin
            for (int i = 0; i < NB; i++) begin
                if (wstrb[i]) begin
                    mem_q[wIdxFull[IW-1:0]][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lastWrite_q <= 1'b0;
            bvalid_q    <= 1'b0;
            berr_q      <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rerr_q      <= 1'b0;
            rdIdx_q     <= '0;
            rdErr_q     <= 1'b0;
            waitCnt_q   <= '0;
            wrCnt_q     <= '0;
            rdCnt_q     <= '0;
            errCnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wHs) begin
                        state_q     <= WR_RESP;
                        lastWrite_q <= 1'b1;
                        bvalid_q    <= 1'b1;
                        berr_q      <= wErr;
                        wrCnt_q     <= satInc(wrCnt_q);
                    end else if (rHs) begin
                        lastWrite_q <= 1'b0;
                        rdCnt_q     <= satInc(rdCnt_q);
                        rdIdx_q     <= rIdxFull[IW-1:0];
                        rdErr_q     <= rErr;
                        if (RD_LATENCY <= 1) begin
                            state_q  <= RD_RESP;
                            rvalid_q <= 1'b1;
                            rerr_q   <= rErr;
                            rdata_q  <= rErr ? '0 : mem_q[rIdxFull[IW-1:0]];
                        end else begin
                            state_q   <= RD_WAIT;
                            waitCnt_q <= WAIT_INIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (waitCnt_q == 3'd0) begin
                        state_q  <= RD_RESP;
                        rvalid_q <= 1'b1;
                        rerr_q   <= rdErr_q;
                        rdata_q  <= rdErr_q ? '0 : mem_q[rdIdx_q];
                    end else begin
                        waitCnt_q <= waitCnt_q - 3'd1;
                    end
                end
                WR_RESP: begin
                    if (bHs) begin
                        state_q  <= IDLE;
                        bvalid_q <= 1'b0;
                        berr_q   <= 1'b0;
                        if (berr_q) errCnt_q <= satInc(errCnt_q);
                    end
                end
                RD_RESP: begin
                    if (rdHs) begin
                        state_q  <= IDLE;
                        rvalid_q <= 1'b0;
                        if (rerr_q) errCnt_q <= satInc(errCnt_q);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bvalid    = bvalid_q;
    assign berr      = berr_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign rerr      = rerr_q;
    assign wr_count  = wrCnt_q;
    assign rd_count  = rdCnt_q;
    assign err_count = errCnt_q;
    assign state     = state_q;

endmodule
